// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and widths for the uart_tx arbiter
//
// Purpose: one place for the arbiter FSM state type and the default UART byte width,
//          so that the top and any future sibling blocks agree on them.
// Contents:
//   UART_DATA_W  default byte width of uart_tx
//   state_t      ST_IDLE, ST_SEND, ST_ACK, ST_DRAIN
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner select
//
// Purpose: finds the first set request bit scanning ptr, ptr+1, ... modulo N_REQ.
// Ports:
//   req  in   N_REQ  request vector
//   ptr  in   ID_W   index with highest priority this round
//   any  out  1      at least one request bit is set
//   idx  out  ID_W   winning index (0 when any is low)
module uart_tx_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  // ptr + k folded back into 0..N_REQ-1; works for non-power-of-two N_REQ
  function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest offset down to ptr so the nearest set bit wins last
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[slot(ptr, k)]) begin
        any = 1'b1;
        idx = slot(ptr, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx between N_REQ byte producers
//
// Purpose: grants one byte per turn, holds it on tx_data with tx_start high until
//          uart_tx reports done, pulses the owner's ack, then waits for done to fall.
// Ports:
//   rst       in   1             asynchronous active-high reset
//   clk       in   1             system clock
//   req       in   N_REQ         requester i holds a byte
//   req_data  in   N_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   ack       out  N_REQ         one-cycle pulse, byte of requester i has left the line
//   busy      out  1             FSM not idle
//   grant_id  out  ID_W          requester being served
//   tx_data   out  DATA_W        registered byte to uart_tx
//   tx_start  out  1             start level to uart_tx
//   tx_done   in   1             done from uart_tx
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int ID_W   = 2
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_done
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t              state, state_nx;
  logic [ID_W-1:0]     ptr, ptr_nx;
  logic [ID_W-1:0]     grant_nx;
  logic [DATA_W-1:0]   data_nx;
  logic                start_nx;
  logic [N_REQ-1:0]    ack_nx;
  logic                pick_any;
  logic [ID_W-1:0]     pick_idx;
  logic [DATA_W-1:0]   req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack      <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      grant_id <= grant_nx;
      tx_data  <= data_nx;
      tx_start <= start_nx;
      ack      <= ack_nx;
    end
  end

  // Outputs are registered: values computed here appear in the state being entered,
  // so tx_start/ack are already correct during SEND and ACK respectively.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant_id;
    data_nx  = tx_data;
    start_nx = tx_start;
    ack_nx   = '0;
    case (state)
      ST_IDLE: begin
        // tx_done is deliberately not looked at here
        if (pick_any) begin
          state_nx = ST_SEND;
          grant_nx = pick_idx;
          data_nx  = req_bytes[pick_idx];
          start_nx = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          state_nx         = ST_ACK;
          start_nx         = 1'b0;
          ack_nx[grant_id] = 1'b1;
        end
      end
      ST_ACK: begin
        state_nx = ST_DRAIN;
        ptr_nx   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      ST_DRAIN: begin
        // a level-style done may still be high; wait it out so it is not seen twice
        if (!tx_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_POST  = 2;
  localparam int P_DRAIN = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [1:0]     grant_id;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(2)) dut (
    .rst      (rst),
    .clk      (clk),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done)
  );

  // uart_tx stand-in: done rises 10 cycles after start, falls 1 cycle after start drops
  int   ucnt;
  logic done_q;
  logic done_force = 1'b0;
  assign tx_done = done_q | done_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt   <= 0;
      done_q <= 1'b0;
    end else if (!tx_start) begin
      ucnt   <= 0;
      done_q <= 1'b0;
    end else if (ucnt == 9) begin
      done_q <= 1'b1;
    end else begin
      ucnt <= ucnt + 1;
    end
  end

  // inputs as seen by the DUT at the last rising edge
  logic [N-1:0]   req_e;
  logic [N*W-1:0] data_e;
  logic           done_e;
  always @(posedge clk) begin
    req_e  <= req;
    data_e <= req_data;
    done_e <= tx_done;
  end

  // reference model state
  int m_phase = P_IDLE;
  int m_ptr   = 0;
  int m_gid   = 0;
  bit auto_mode = 1'b0;
  bit pend [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic produce();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        pend[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end else begin
          req[i] = 1'b0;
        end
      end else if (pend[i]) begin
        // byte in flight: occasionally withdraw and scribble on the data
        if (m_phase == P_WAIT && m_gid == i && req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
          req_data[i*W +: W] = W'($urandom);
        end
      end else if ($urandom_range(0, 2 + 2 * i) == 0) begin
        pend[i] = 1'b1;
        req[i] = 1'b1;
        req_data[i*W +: W] = W'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_ack;
    int w;
    @(negedge clk);
    exp_ack = '0;
    if (rst) begin
      chk("rst_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_data", tx_data, 0);
      m_phase = P_IDLE;
      m_ptr = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          w = pick(req_e, m_ptr);
          if (w >= 0) begin
            m_gid = w;
            chk("grant_busy", busy, 1);
            chk("grant_start", tx_start, 1);
            chk("grant_id", grant_id, w);
            chk("grant_data", tx_data, data_e[w*W +: W]);
            m_phase = P_WAIT;
          end else begin
            chk("idle_busy", busy, 0);
            chk("idle_start", tx_start, 0);
          end
        end
        P_WAIT: begin
          chk("send_busy", busy, 1);
          if (done_e) begin
            exp_ack[m_gid] = 1'b1;
            chk("ack_start", tx_start, 0);
            m_phase = P_POST;
          end else begin
            chk("send_start", tx_start, 1);
          end
        end
        P_POST: begin
          m_ptr = (m_gid + 1) % N;
          chk("post_busy", busy, 1);
          chk("post_start", tx_start, 0);
          m_phase = P_DRAIN;
        end
        default: begin
          if (!done_e) begin
            chk("drain_exit", busy, 0);
            m_phase = P_IDLE;
          end else begin
            chk("drain_hold", busy, 1);
          end
        end
      endcase
    end
    chk("ack", ack, exp_ack);
    if (auto_mode) produce();
  endtask

  task automatic run_until_ack(output logic [N-1:0] a);
    a = '0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
    chk("ack_seen", a != '0, 1);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [N-1:0] a;
  int rr_order [5] = '{0, 1, 2, 3, 0};
  int skip_order [4] = '{0, 3, 0, 3};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset with every requester active
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'hA0 + i);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t1_gid", grant_id, 0);
    chk("t1_data", tx_data, 8'hA0);
    run_until_ack(a);
    chk("t1_ack", a, 4'b0001);
    req = '0;
    repeat (4) step();

    // single requester
    req_data[2*W +: W] = 8'h41;
    req = 4'b0100;
    step();
    chk("t2_data", tx_data, 8'h41);
    chk("t2_start", tx_start, 1);
    run_until_ack(a);
    chk("t2_ack", a, 4'b0100);
    req = '0;
    repeat (4) step();
    chk("t2_idle", busy, 0);

    // round robin with all held high
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_until_ack(a);
      chk("t3_ack", a, 4'b0001 << rr_order[k]);
      chk("t3_byte", tx_data, 8'h10 + rr_order[k]);
    end
    req = '0;
    repeat (4) step();

    // inactive requesters are skipped
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      run_until_ack(a);
      chk("t4_ack", a, 4'b0001 << skip_order[k]);
    end
    req = '0;
    repeat (4) step();

    // withdraw and corrupt during SEND
    do_reset();
    req_data[1*W +: W] = 8'h5A;
    req = 4'b0010;
    repeat (4) step();
    req[1] = 1'b0;
    req_data[1*W +: W] = 8'hFF;
    run_until_ack(a);
    chk("t5_ack", a, 4'b0010);
    chk("t5_byte", tx_data, 8'h5A);
    repeat (4) step();

    // reset in the middle of SEND
    do_reset();
    req = 4'b0001;
    run_until_ack(a);
    req = 4'b0010;
    repeat (6) step();
    chk("t6_pre_start", tx_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_start", tx_start, 0);
    chk("t6_async_busy", busy, 0);
    req = 4'b1111;
    step();
    step();
    rst = 1'b0;
    step();
    chk("t6_restart_gid", grant_id, 0);
    run_until_ack(a);
    chk("t6_ack", a, 4'b0001);
    req = '0;
    repeat (4) step();

    // done while idle is ignored
    done_force = 1'b1;
    repeat (3) step();
    chk("t7_busy", busy, 0);
    done_force = 1'b0;
    repeat (3) step();

    // randomized producers
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    auto_mode = 1'b1;
    repeat (3000) step();
    auto_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
